adsu_pipe: RTL and testbench
============================

// Module: adsu_pipe
// PURPOSE
//  Parametrised, pipelined two's-complement add/subtract unit with valid/ready
//  handshake and carry/overflow flags. Successor to the fixed 9-bit combinational
//  add/sub used in the Cartesian-to-polar datapath (CORDIC x/y/z update stages).
//  Sits between CORDIC iteration registers and the next stage; absorbs backpressure.
// PARAMETERS
//  W    9  operand/result width in bits (2..32)
//  LAT  2  pipeline latency in cycles, accept to OUT_VALID (1..4)
// PORTS
//  CLK         in   1  single clock; all state on rising edge
//  RST_N       in   1  reset, asynchronous assert, active-low
//  A           in   W  operand A, signed two's complement
//  B           in   W  operand B, signed two's complement
//  CI          in   1  carry-in (ADD=1) / not-borrow-in (ADD=0)
//  ADD         in   1  1: add, 0: subtract
//  IN_VALID    in   1  operands valid
//  IN_READY    out  1  unit accepts operands this cycle
//  S           out  W  result
//  CO          out  1  carry-out (ADD=1) / not-borrow-out (ADD=0)
//  OFL         out  1  signed overflow of this result
//  OUT_VALID   out  1  S/CO/OFL valid
//  OUT_READY   in   1  downstream accepts result
//  CLR         in   1  synchronous clear of OFL_STICKY
//  OFL_STICKY  out  1  set by any transferred result with OFL=1
// BEHAVIOUR
//  - Arithmetic (stage 1): {CO,S_raw} = A + (ADD ? B : ~B) + CI, W+1 bits.
//    Sub with CI=1 gives A-B; CI=0 gives A-B-1. OFL = signed overflow of that op
//    (operand signs as seen by adder equal, result sign differs). Stages 2..LAT delay only.
//  - Pipeline: LAT stages, each with valid bit. Global advance = !OUT_VALID | OUT_READY.
//    IN_READY = advance (combinational from OUT_VALID, OUT_READY). Accept = IN_VALID & IN_READY.
//    On advance every stage shifts; stage 1 valid loads IN_VALID. Bubbles not collapsed.
//  - Output transfer = OUT_VALID & OUT_READY. While OUT_VALID & !OUT_READY all stages hold;
//    S/CO/OFL stable until transfer.
//  - Throughput 1 op/cycle with OUT_READY held high; latency exactly LAT cycles.
//  - OFL_STICKY: set on transfer with OFL=1; cleared by CLR; same-cycle set and CLR -> set wins.
//  - Reset (RST_N=0, async): all valid bits 0, OUT_VALID=0, S=0, CO=0, OFL=0, OFL_STICKY=0.
//    In-flight ops discarded. IN_READY=1 during/after reset (pipe empty).
//  - Wrap: without saturation S = S_raw mod 2^W (e.g. W=9: 255+1 -> 0x100).
//  - Operand/ADD/CI values ignored when IN_VALID=0; invalid stages may hold stale data.
// CONFIGURATION
//  ADSU_SAT_EN defined: when OFL=1, S clamps to max positive (0x0FF for W=9) if the true
//   result is positive, min negative (0x100) if negative; CO and OFL still report raw
//   values. Clamp applied in stage 1; latency unchanged.
//  ADSU_SAT_EN undefined: S wraps modulo 2^W; no clamp logic present.
// TESTING (W=9, LAT=2 unless stated)
//  1 reset: RST_N low mid-stream with 2 ops in flight -> OUT_VALID=0, S=0, OFL_STICKY=0
//    immediately; no stale result emerges after release.
//  2 add/sub: A=5,B=3,ADD=0,CI=1 -> S=0x002,CO=1,OFL=0; A=3,B=5,ADD=0,CI=1 -> S=0x1FE,CO=0;
//    A=7,B=1,ADD=1,CI=1 -> S=0x009; each exactly 2 cycles after accept.
//  3 overflow: A=255,B=1,ADD=1,CI=0 -> OFL=1, S=0x100 (wrap) / 0x0FF (ADSU_SAT_EN);
//    A=0x100,B=1,ADD=0,CI=1 -> OFL=1, S=0x0FF / 0x100 (SAT); OFL_STICKY=1 after transfer.
//  4 backpressure: stream 8 ops, OUT_READY low for 3 cycles mid-stream -> IN_READY low
//    same cycles, S held stable, all 8 results in order, none lost or duplicated.
//  5 sticky: CLR=1 in same cycle as transfer with OFL=1 -> OFL_STICKY stays 1; CLR alone -> 0.
//  6 sweep LAT=1 and LAT=4, W=16: random ops vs reference model, latency = LAT, full rate.

Source files
------------

// File: rtl/adsu_pipe.sv
// adsu_pipe: pipelined two's-complement add/sub with valid/ready handshake, carry and overflow.
// Define ADSU_SAT_EN to clamp overflowed results to the signed range limits.
module adsu_pipe #(
  parameter int unsigned W   = 9,
  parameter int unsigned LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  input  logic         add_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         ofl_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  input  logic         clr_i,
  output logic         ofl_sticky_o
);

  localparam int unsigned WS = W + 1;

  logic [W-1:0] bb_c;
  logic [W:0]   sum_c;
  logic [W-1:0] s1_c;
  logic         ofl1_c;
  logic         advance_c;
  logic         xfer_c;

  logic [W-1:0] s_q   [LAT];
  logic         co_q  [LAT];
  logic         ofl_q [LAT];
  logic         vld_q [LAT];
  logic         sticky_q;
  logic         sticky_d;

  // Stage-1 arithmetic; overflow when adder inputs share a sign the result lacks.
  always_comb begin
    bb_c   = add_i ? b_i : ~b_i;
    sum_c  = WS'(a_i) + WS'(bb_c) + WS'(ci_i);
    ofl1_c = (a_i[W-1] == bb_c[W-1]) && (sum_c[W-1] != a_i[W-1]);
`ifdef ADSU_SAT_EN
    s1_c   = ofl1_c ? (a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                    : sum_c[W-1:0];
`else
    s1_c   = sum_c[W-1:0];
`endif
  end

  // Whole pipe moves together; bubbles are kept rather than collapsed.
  always_comb begin
    advance_c = !vld_q[LAT-1] || out_ready_i;
    xfer_c    = vld_q[LAT-1] && out_ready_i;
    sticky_d  = sticky_q;
    if (clr_i) begin
      sticky_d = 1'b0;
    end
    if (xfer_c && ofl_q[LAT-1]) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LAT); i++) begin
        s_q[i]   <= '0;
        co_q[i]  <= 1'b0;
        ofl_q[i] <= 1'b0;
        vld_q[i] <= 1'b0;
      end
    end else if (advance_c) begin
      vld_q[0] <= in_valid_i;
      if (in_valid_i) begin
        s_q[0]   <= s1_c;
        co_q[0]  <= sum_c[W];
        ofl_q[0] <= ofl1_c;
      end
      for (int i = 1; i < int'(LAT); i++) begin
        s_q[i]   <= s_q[i-1];
        co_q[i]  <= co_q[i-1];
        ofl_q[i] <= ofl_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign in_ready_o   = advance_c;
  assign s_o          = s_q[LAT-1];
  assign co_o         = co_q[LAT-1];
  assign ofl_o        = ofl_q[LAT-1];
  assign out_valid_o  = vld_q[LAT-1];
  assign ofl_sticky_o = sticky_q;

endmodule

// File: tb/tb_adsu_pipe.sv
// Bench for adsu_pipe: directed W=9/LAT=2 steps plus random W=16 sweeps at LAT=1 and LAT=4.
`timescale 1ns/1ps
module tb_adsu_pipe;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ofl;
    int          t;
    bit          lat;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] a0, b0, s0;
  logic ci0, add0, iv0, ir0, co0, ofl0, ov0, or0, clr0, st0;

  logic [15:0] a16, b16, s1, s4;
  logic ci16, add16, iv16, or16, clr16;
  logic ir1, co1, ofl1, ov1, st1;
  logic ir4, co4, ofl4, ov4, st4;

  adsu_pipe #(.W(9), .LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .a_i(a0), .b_i(b0), .ci_i(ci0), .add_i(add0),
    .in_valid_i(iv0), .in_ready_o(ir0), .s_o(s0), .co_o(co0), .ofl_o(ofl0),
    .out_valid_o(ov0), .out_ready_i(or0), .clr_i(clr0), .ofl_sticky_o(st0));

  adsu_pipe #(.W(16), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a_i(a16), .b_i(b16), .ci_i(ci16), .add_i(add16),
    .in_valid_i(iv16), .in_ready_o(ir1), .s_o(s1), .co_o(co1), .ofl_o(ofl1),
    .out_valid_o(ov1), .out_ready_i(or16), .clr_i(clr16), .ofl_sticky_o(st1));

  adsu_pipe #(.W(16), .LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a_i(a16), .b_i(b16), .ci_i(ci16), .add_i(add16),
    .in_valid_i(iv16), .in_ready_o(ir4), .s_o(s4), .co_o(co4), .ofl_o(ofl4),
    .out_valid_o(ov4), .out_ready_i(or16), .clr_i(clr16), .ofl_sticky_o(st4));

  int    checks = 0;
  int    errors = 0;
  int    cyc_n = 0;
  int    cnt1 = 0;
  int    cnt4 = 0;
  bit    lat_chk = 1'b1;
  bit    acc0;
  logic  exp_st1 = 1'b0;
  logic  exp_st4 = 1'b0;
  item_t q0[$];
  item_t q1[$];
  item_t q4[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ofl, co, s} for a w-bit operation.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic add, input int w);
    logic [32:0] mask, ua, ub, sum;
    logic [31:0] s;
    logic sa, sb, ss, co, ofl;
    mask = (33'd1 << w) - 33'd1;
    ua   = {1'b0, a} & mask;
    ub   = (add ? {1'b0, b} : ~{1'b0, b}) & mask;
    sum  = ua + ub + 33'(ci);
    s    = 32'(sum & mask);
    co   = sum[w];
    sa   = ua[w-1];
    sb   = ub[w-1];
    ss   = sum[w-1];
    ofl  = (sa == sb) && (ss != sa);
`ifdef ADSU_SAT_EN
    if (ofl) s = sa ? 32'(33'd1 << (w-1)) : 32'(mask >> 1);
`endif
    return {ofl, co, s};
  endfunction

  function automatic item_t mk(input logic [31:0] a, input logic [31:0] b, input logic ci,
                               input logic add, input int w, input bit lat);
    item_t it;
    logic [33:0] r;
    r      = ref_op(a, b, ci, add, w);
    it.s   = r[15:0];
    it.co  = r[32];
    it.ofl = r[33];
    it.t   = cyc_n;
    it.lat = lat;
    return it;
  endfunction

  task automatic cmp(input string tag, input item_t it, input logic [15:0] s,
                     input logic co, input logic ofl, input int lat);
    check({tag, "_s"}, 32'(s), 32'(it.s));
    check({tag, "_co"}, 32'(co), 32'(it.co));
    check({tag, "_ofl"}, 32'(ofl), 32'(it.ofl));
    if (it.lat) check({tag, "_lat"}, 32'(cyc_n - it.t), 32'(lat));
  endtask

  // One clock: score outputs and accepts just before the edge, return at the next negedge.
  task automatic tick();
    item_t it;
    #1;
    acc0 = iv0 && ir0;
    if (ov0 && or0) begin
      if (q0.size() == 0) check("u0_extra", 32'(ov0), 32'd0);
      else begin it = q0.pop_front(); cmp("u0", it, 16'(s0), co0, ofl0, 2); end
    end
    if (acc0) q0.push_back(mk(32'(a0), 32'(b0), ci0, add0, 9, lat_chk));
    if (ov1 && or16) begin
      if (q1.size() == 0) check("u1_extra", 32'(ov1), 32'd0);
      else begin it = q1.pop_front(); if (it.ofl) exp_st1 = 1'b1; cmp("u1", it, s1, co1, ofl1, 1); end
    end
    if (iv16 && ir1) begin cnt1++; q1.push_back(mk(32'(a16), 32'(b16), ci16, add16, 16, 1'b1)); end
    if (ov4 && or16) begin
      if (q4.size() == 0) check("u4_extra", 32'(ov4), 32'd0);
      else begin it = q4.pop_front(); if (it.ofl) exp_st4 = 1'b1; cmp("u4", it, s4, co4, ofl4, 4); end
    end
    if (iv16 && ir4) begin cnt4++; q4.push_back(mk(32'(a16), 32'(b16), ci16, add16, 16, 1'b1)); end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic drv0(input logic [8:0] a, input logic [8:0] b, input logic ci, input logic add);
    a0 = a; b0 = b; ci0 = ci; add0 = add; iv0 = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] held;
    logic [8:0] sat_pos, sat_neg;
    int n;
`ifdef ADSU_SAT_EN
    sat_pos = 9'h0FF; sat_neg = 9'h100;
`else
    sat_pos = 9'h100; sat_neg = 9'h0FF;
`endif
    a0 = '0; b0 = '0; ci0 = 0; add0 = 0; iv0 = 0; or0 = 1; clr0 = 0;
    a16 = '0; b16 = '0; ci16 = 0; add16 = 0; iv16 = 0; or16 = 1; clr16 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ov", 32'(ov0), 32'd0);
    check("rst_s", 32'(s0), 32'd0);
    check("rst_co", 32'(co0), 32'd0);
    check("rst_ofl", 32'(ofl0), 32'd0);
    check("rst_sticky", 32'(st0), 32'd0);
    check("rst_ready", 32'(ir0), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Add/sub with exact latency
    drv0(9'd5, 9'd3, 1'b1, 1'b0); tick();
    iv0 = 1'b0;
    #1 check("lat_early", 32'(ov0), 32'd0);
    tick();
    #1;
    check("sub_ov", 32'(ov0), 32'd1);
    check("sub_s", 32'(s0), 32'h002);
    check("sub_co", 32'(co0), 32'd1);
    check("sub_ofl", 32'(ofl0), 32'd0);
    drv0(9'd3, 9'd5, 1'b1, 1'b0); tick();
    drv0(9'd7, 9'd1, 1'b1, 1'b1); tick();
    iv0 = 1'b0;
    #1 check("neg_s", 32'(s0), 32'h1FE);
    tick();
    #1 check("add_s", 32'(s0), 32'h009);
    repeat (3) tick();
    check("sticky_pre", 32'(st0), 32'd0);

    // Overflow both directions
    drv0(9'd255, 9'd1, 1'b0, 1'b1); tick();
    drv0(9'h100, 9'd1, 1'b1, 1'b0); tick();
    iv0 = 1'b0;
    #1;
    check("ofl_pos_s", 32'(s0), 32'(sat_pos));
    check("ofl_pos_f", 32'(ofl0), 32'd1);
    tick();
    #1;
    check("ofl_neg_s", 32'(s0), 32'(sat_neg));
    check("ofl_neg_f", 32'(ofl0), 32'd1);
    tick();
    check("sticky_set", 32'(st0), 32'd1);

    // Sticky clear vs set priority
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    check("sticky_clr", 32'(st0), 32'd0);
    drv0(9'd255, 9'd1, 1'b0, 1'b1); tick();
    iv0 = 1'b0; tick();
    clr0 = 1'b1;
    #1 check("sticky_ofl_out", 32'(ov0 && ofl0), 32'd1);
    tick(); clr0 = 1'b0;
    check("sticky_set_wins", 32'(st0), 32'd1);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    check("sticky_clr2", 32'(st0), 32'd0);

    // Async reset with ops in flight
    drv0(9'd255, 9'd1, 1'b0, 1'b1); tick();
    iv0 = 1'b0; tick(); tick();
    drv0(9'd1, 9'd2, 1'b0, 1'b1); tick();
    drv0(9'd20, 9'd4, 1'b1, 1'b0); tick();
    iv0 = 1'b0;
    check("midrst_pre_st", 32'(st0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ov", 32'(ov0), 32'd0);
    check("midrst_s", 32'(s0), 32'd0);
    check("midrst_st", 32'(st0), 32'd0);
    check("midrst_ready", 32'(ir0), 32'd1);
    q0.delete();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Backpressure: 8 ops, downstream stalls three cycles
    lat_chk = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      or0 = !(k >= 4 && k < 7);
      drv0(9'(n * 37 + 11), 9'(n * 13), n[0], n[1]);
      if (k == 4) held = s0;
      if (k >= 4 && k < 7) begin
        #1 check("bp_ready", 32'(ir0), 32'd0);
        if (k > 4) check("bp_hold", 32'(s0), 32'(held));
      end
      tick();
      if (acc0) n++;
    end
    or0 = 1'b1; iv0 = 1'b0;
    for (int k = 0; k < 20 && q0.size() != 0; k++) tick();
    check("bp_drain", 32'(q0.size()), 32'd0);
    lat_chk = 1'b1;

    // Random full-rate sweep on the W=16 instances
    for (int i = 0; i < 150; i++) begin
      if (i == 0) begin a16 = 16'h7FFF; b16 = 16'h0001; ci16 = 0; add16 = 1; end
      else if (i == 1) begin a16 = 16'h8000; b16 = 16'h0001; ci16 = 1; add16 = 0; end
      else begin
        a16 = 16'($urandom); b16 = 16'($urandom);
        ci16 = 1'($urandom_range(0, 1)); add16 = 1'($urandom_range(0, 1));
      end
      iv16 = 1'b1;
      tick();
    end
    iv16 = 1'b0;
    for (int k = 0; k < 20 && (q1.size() != 0 || q4.size() != 0); k++) tick();
    check("u1_drain", 32'(q1.size()), 32'd0);
    check("u4_drain", 32'(q4.size()), 32'd0);
    check("u1_rate", 32'(cnt1), 32'd150);
    check("u4_rate", 32'(cnt4), 32'd150);
    check("u1_sticky", 32'(st1), 32'(exp_st1));
    check("u4_sticky", 32'(st4), 32'(exp_st4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
